// File: rtl/cla_sub_seq.sv
// Sequential two's-complement subtractor: diff = a - b, one 4-bit carry-lookahead
// slice per cycle (LSB first), behind valid/ready operand and result handshakes.
module cla_sub_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB  = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  nb_q;
  logic [WIDTH-1:0]  diff_q;
  logic [WIDTH-1:0]  diff_nx;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic              borrow_q;
  logic              overflow_q;
  logic              zero_q;
  logic [3:0]        a_nib;
  logic [3:0]        nb_nib;
  logic [4:0]        slice;
  logic              last;

  // Returns {carry_out, sum} for x + y + cin using generate/propagate lookahead terms.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic [3:0] s;
    p    = x ^ y;
    g    = x & y;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & c[0]);
    c[2] = g[2] | (p[2] & c[1]);
    c[3] = g[3] | (p[3] & c[2]);
    s[0] = p[0] ^ cin;
    s[1] = p[1] ^ c[0];
    s[2] = p[2] ^ c[1];
    s[3] = p[3] ^ c[2];
    return {c[3], s};
  endfunction

  // Current slice: operand nibble select, CLA evaluation, merge into running diff
  always_comb begin
    a_nib  = '0;
    nb_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_nib  = a_q[4*i +: 4];
        nb_nib = nb_q[4*i +: 4];
      end
    end
    slice   = cla4(a_nib, nb_nib, carry_q);
    diff_nx = diff_q;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) begin
        diff_nx[4*i +: 4] = slice[3:0];
      end
    end
  end

  assign last = (idx_q == IDXW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Operand capture, slice accumulation and final flag evaluation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      nb_q       <= '0;
      diff_q     <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            nb_q    <= ~b;
            carry_q <= 1'b1;
            idx_q   <= '0;
            diff_q  <= '0;
          end
        end
        RUN: begin
          diff_q  <= diff_nx;
          carry_q <= slice[4];
          if (last) begin
            idx_q      <= '0;
            borrow_q   <= ~slice[4];
            // b's sign bit is the inverse of the stored ~b sign bit
            overflow_q <= (a_q[MSB] == nb_q[MSB]) && (diff_nx[MSB] != a_q[MSB]);
            zero_q     <= (diff_nx == '0);
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_sub_seq.sv
// Directed testbench for cla_sub_seq (WIDTH=32): arithmetic vectors, latency,
// backpressure hold, back-to-back operation and mid-operation reset.
module tb_cla_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int errors = 0;

  cla_sub_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, diff, borrow, overflow, zero} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b diff=%h b=%b o=%b z=%b required all zero",
               out_valid, diff, borrow, overflow, zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [6] = '{32'd5, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000, 32'hA5A5_0F0F};
    logic [31:0] vb [6] = '{32'd3, 32'd1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h5A5A_F0F0};
    logic [31:0] vd [6] = '{32'h2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_FFFF, 32'h4B4A_1E1F};
    logic [2:0]  vf [6] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b000, 3'b010};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i]);
      wait_done(lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL arith_latency[%0d]: got %0d required 8", i, lat);
      end
      checks++;
      if (diff !== vd[i]) begin
        errors++;
        $display("FAIL arith_diff[%0d]: got %h required %h", i, diff, vd[i]);
      end
      checks++;
      if ({borrow, overflow, zero} !== vf[i]) begin
        errors++;
        $display("FAIL arith_flags[%0d]: got b/o/z=%b required %b", i,
                 {borrow, overflow, zero}, vf[i]);
      end
      handshake();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL arith_release[%0d]: got out_valid/in_ready=%b required 01", i,
                 {out_valid, in_ready});
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    start_op(32'h1234_5678, 32'h1234_5678);
    wait_done(lat);
    checks++;
    if (lat !== 8 || diff !== 32'h0 || {borrow, overflow, zero} !== 3'b001) begin
      errors++;
      $display("FAIL bp_result: got lat=%0d diff=%h b/o/z=%b required 8 00000000 001",
               lat, diff, {borrow, overflow, zero});
    end
    in_valid = 1'b1;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0000_0001;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 32'h0 || zero !== 1'b1) begin
        errors++;
        bad++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b diff=%h z=%b required 1 0 00000000 1",
                 c, out_valid, in_ready, diff, zero);
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0) begin
      errors++;
      $display("FAIL bp_release: got ir=%b ov=%b diff=%h required 1 0 00000000",
               in_ready, out_valid, diff);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    a         = 32'd100;
    b         = 32'd30;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
      a = $urandom;
      b = $urandom;
    end
    checks++;
    if (lat !== 8 || diff !== 32'd70 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d diff=%h ir=%b required 8 00000046 0",
               lat, diff, in_ready);
    end
    a = 32'd50;
    b = 32'd60;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got ov=%b ir=%b required 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_pulse: got ir=%b required 0", in_ready);
    end
    a = 32'hFFFF_FFFF;
    b = 32'h0;
    wait_done(lat);
    checks++;
    if (lat !== 8 || diff !== 32'hFFFF_FFF6 || {borrow, overflow, zero} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d diff=%h b/o/z=%b required 8 fffffff6 100",
               lat, diff, {borrow, overflow, zero});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got ir=%b ov=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen = 0;
    start_op(32'h0000_FFFF, 32'h0000_0001);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_immediate: got ov=%b ir=%b diff=%h required 0 1 00000000",
               out_valid, in_ready, diff);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_no_valid: got %0d out_valid cycles required 0", seen);
    end
    start_op(32'd10, 32'd4);
    wait_done(lat);
    checks++;
    if (lat !== 8 || diff !== 32'd6 || {borrow, overflow, zero} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_next_op: got lat=%0d diff=%h b/o/z=%b required 8 00000006 000",
               lat, diff, {borrow, overflow, zero});
    end
    handshake();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
